// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer between the result path and the
// register file write port. Accepts writes via valid/ready, drains one entry
// per cycle unless held, and offers a forwarding lookup on rs1/rs2.
// Optional feature macro: WB_QUEUE_FWD_EN (builds the forwarding lookup;
// when undefined the fwd* outputs are tied to zero).
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     hold,
    output logic                     RegWrite,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          WriteData,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];

    logic [AW-1:0]   head_idx;
    logic [AW-1:0]   tail_idx;
    logic            empty_c;
    logic            full_c;
    logic            push_c;
    logic            pop_c;

    // Occupancy status decoded from the extended pointers.
    always_comb begin
        head_idx = rptr_q[AW-1:0];
        tail_idx = wptr_q[AW-1:0];
        empty_c  = (wptr_q == rptr_q);
        full_c   = (head_idx == tail_idx) && (wptr_q[AW] != rptr_q[AW]);
        count    = wptr_q - rptr_q;
    end

    // Drain port, handshake and push/pop qualification.
    always_comb begin
        RegWrite  = !empty_c && !hold;
        rd        = RegWrite ? rd_mem_q[head_idx] : 5'd0;
        WriteData = RegWrite ? data_mem_q[head_idx] : '0;
        in_ready  = !full_c || RegWrite;
        pop_c     = RegWrite;
        // x0 writes complete the handshake but are never stored.
        push_c    = in_valid && in_ready && (in_rd != 5'd0);
    end

    // Next pointer and storage state.
    always_comb begin
        wptr_d     = wptr_q + PW'(push_c);
        rptr_d     = rptr_q + PW'(pop_c);
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push_c) begin
            rd_mem_d[tail_idx]   = in_rd;
            data_mem_d[tail_idx] = in_data;
        end
    end

    // State registers; reset discards every pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

`ifdef WB_QUEUE_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Forwarding lookup: walk head to tail so the newest match wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        fwd_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_idx + AW'(i);
            if (PW'(i) < count) begin
                if ((rs1 != 5'd0) && (rd_mem_q[fwd_idx] == rs1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_mem_q[fwd_idx];
                end
                if ((rs2 != 5'd0) && (rd_mem_q[fwd_idx] == rs2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_mem_q[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_lookup;

    // Lookup not built: forwarding outputs tied off, lookup indices unused.
    always_comb begin
        fwd1_hit      = 1'b0;
        fwd2_hit      = 1'b0;
        fwd1_data     = '0;
        fwd2_data     = '0;
        unused_lookup = ^{rs1, rs2};
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed test-plan steps plus a
// randomized phase, all checked against a queue-based reference model.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic            hold;
    logic            RegWrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] WriteData;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
    logic [CW-1:0]   count;

    int checks;
    int errors;

    ent_t            q[$];
    logic [XLEN-1:0] rf_model [32];
    logic [XLEN-1:0] rf_dut   [32];

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .hold(hold),
        .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest pending value for a register, from the model queue.
    task automatic fwd_model(input logic [4:0] rs, output logic hit, output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
`ifdef WB_QUEUE_FWD_EN
        if (rs != 5'd0)
            for (int i = 0; i < q.size(); i++)
                if (q[i].rd == rs) begin
                    hit  = 1'b1;
                    data = q[i].data;
                end
`endif
    endtask

    // One clock cycle: drive, check all outputs against the model, advance.
    task automatic step(input bit v, input logic [4:0] r, input logic [XLEN-1:0] d,
                        input bit h, input logic [4:0] a, input logic [4:0] b);
        bit              e_rw;
        bit              e_ready;
        logic            e_h1, e_h2;
        logic [XLEN-1:0] e_d1, e_d2;
        @(negedge clk);
        in_valid = v; in_rd = r; in_data = d; hold = h; rs1 = a; rs2 = b;
        #1;
        e_rw    = (q.size() != 0) && !h;
        e_ready = (q.size() < DEPTH) || e_rw;
        fwd_model(a, e_h1, e_d1);
        fwd_model(b, e_h2, e_d2);
        check("RegWrite", 64'(RegWrite), 64'(e_rw));
        check("rd", 64'(rd), e_rw ? 64'(q[0].rd) : 64'd0);
        check("WriteData", 64'(WriteData), e_rw ? 64'(q[0].data) : 64'd0);
        check("in_ready", 64'(in_ready), 64'(e_ready));
        check("count", 64'(count), 64'(q.size()));
        check("fwd1_hit", 64'(fwd1_hit), 64'(e_h1));
        check("fwd1_data", 64'(fwd1_data), 64'(e_d1));
        check("fwd2_hit", 64'(fwd2_hit), 64'(e_h2));
        check("fwd2_data", 64'(fwd2_data), 64'(e_d2));
        if (RegWrite === 1'b1) rf_dut[rd] = WriteData;
        if (e_rw) begin
            rf_model[q[0].rd] = q[0].data;
            void'(q.pop_front());
        end
        if (v && e_ready && (r != 5'd0)) q.push_back('{rd: r, data: d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit h);
        step(1'b0, 5'd0, '0, h, 5'd0, 5'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_RegWrite"}, 64'(RegWrite), 64'd0);
        check({tag, "_rd"}, 64'(rd), 64'd0);
        check({tag, "_WriteData"}, 64'(WriteData), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_fwd_hit"}, 64'({fwd1_hit, fwd2_hit}), 64'd0);
        check({tag, "_fwd1_data"}, 64'(fwd1_data), 64'd0);
        check({tag, "_fwd2_data"}, 64'(fwd2_data), 64'd0);
    endtask

    initial begin
        logic [4:0]      r;
        logic [XLEN-1:0] snap [32];
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = '0;
            rf_dut[i]   = '0;
        end
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        hold = 1'b0; rs1 = '0; rs2 = '0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write: visible on the port the cycle after acceptance.
        step(1'b1, 5'd5, 32'd123, 1'b0, 5'd0, 5'd0);
        check("basic_RegWrite", 64'(RegWrite), 64'd1);
        check("basic_rd", 64'(rd), 64'd5);
        check("basic_WriteData", 64'(WriteData), 64'd123);
        idle(1'b0);
        check("basic_count", 64'(count), 64'd0);
        check("basic_rf5", 64'(rf_dut[5]), 64'd123);

        // Fill under hold, then drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(10 * i), 1'b1, 5'd0, 5'd0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check("fill_drained", 64'(count), 64'd0);
        check("fill_rf4", 64'(rf_dut[4]), 64'd40);

        // Full queue: push and pop in the same cycle.
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i + 10), 32'(i), 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd6, 32'd99, 1'b0, 5'd0, 5'd0);
        check("fullpp_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check("fullpp_rf6", 64'(rf_dut[6]), 64'd99);

        // Forwarding of duplicate destination registers.
        step(1'b1, 5'd7, 32'd1, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd7, 32'd2, 1'b1, 5'd0, 5'd0);
        step(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0);
`ifdef WB_QUEUE_FWD_EN
        check("fwd_hit1", 64'(fwd1_hit), 64'd1);
        check("fwd_data1", 64'(fwd1_data), 64'd2);
`else
        check("fwd_hit1_off", 64'(fwd1_hit), 64'd0);
        check("fwd_data1_off", 64'(fwd1_data), 64'd0);
`endif
        check("fwd_hit2_x0", 64'(fwd2_hit), 64'd0);
        step(1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd7);
        step(1'b0, 5'd0, '0, 1'b0, 5'd7, 5'd7);
        check("fwd_after_drain", 64'({fwd1_hit, fwd2_hit}), 64'd0);
        check("fwd_rf7", 64'(rf_dut[7]), 64'd2);

        // x0 write completes the handshake but is dropped.
        step(1'b1, 5'd0, 32'd55, 1'b0, 5'd0, 5'd0);
        check("x0_count", 64'(count), 64'd0);
        check("x0_RegWrite", 64'(RegWrite), 64'd0);

        // Randomized traffic with heavy register aliasing.
        for (int n = 0; n < 400; n++) begin
            r = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 3) != 0), r, $urandom(),
                 1'($urandom_range(0, 9) < 3),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 6; n++) idle(1'b0);
        for (int i = 0; i < 32; i++) check($sformatf("rand_rf%0d", i), 64'(rf_dut[i]), 64'(rf_model[i]));

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) step(1'b1, 5'(20 + i), 32'(500 + i), 1'b1, 5'd0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0; hold = 1'b0; rs1 = 5'd20; rs2 = 5'd21;
        #1;
        check("midrst_pre_RegWrite", 64'(RegWrite), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #1;
        rst_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) snap[i] = rf_model[i];
        for (int n = 0; n < 4; n++) idle(1'b0);
        for (int i = 20; i < 23; i++) check($sformatf("midrst_rf%0d", i), 64'(rf_dut[i]), 64'(snap[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback write queue between the execute/load result path and the `RegFile` write port. It accepts destination-register writes through a valid/ready handshake and buffers them in an in-order FIFO. It drains one write per cycle into `RegFile` by driving `RegWrite`/`rd`/`WriteData`. Readers can get pending values early through a forwarding lookup on `rs1`/`rs2`.

## Interface
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.
- `XLEN`, default 32: data width.

- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a write.
- `in_ready`  out  1  queue accepts this cycle.
- `in_rd`  in  5  destination register index.
- `in_data`  in  XLEN  value to write.
- `hold`  in  1  suppresses draining this cycle.
- `RegWrite`  out  1  write strobe to `RegFile`.
- `rd`  out  5  write index to `RegFile`.
- `WriteData`  out  XLEN  write data to `RegFile`.
- `rs1`, `rs2`  in  5 each  lookup indices (same as `RegFile` read ports).
- `fwd1_hit`, `fwd2_hit`  out  1 each  pending entry matches `rs1`/`rs2`.
- `fwd1_data`, `fwd2_data`  out  XLEN each  newest pending value for `rs1`/`rs2`.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Storage:** circular buffer with `$clog2(DEPTH)+1`-bit read/write pointers. The extra MSB distinguishes full from empty.
  - empty = pointers equal.
  - full = indices equal and MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
- **Push:** occurs when `in_valid && in_ready` and `in_rd != 0`.
- **x0 writes:** `in_valid && in_ready` with `in_rd == 0` is accepted (handshake completes) but not enqueued.
- **Drain:** `RegWrite = !empty && !hold`.
  - `rd` and `WriteData` show the head entry when `RegWrite` is 1, otherwise 0.
  - Pop occurs at the posedge where `RegWrite` is 1.
- **Ready:** `in_ready = !full || RegWrite`.
  - When full, push and pop in the same cycle are allowed.
  - When empty, push and pop in the same cycle cannot occur, because the head is not valid yet.
- **Ordering:** strict FIFO. Duplicate `rd` values are preserved in order, so `RegFile` ends with the newest value.
- **Forwarding:** for each port, scan the valid entries from tail (newest) to head.
  - `fwdN_hit` = 1 if any entry's `rd` equals `rsN` and `rsN != 0`.
  - `fwdN_data` = the newest match's data, or 0 when there is no hit.
  - The head entry being drained this cycle still counts as a match.
  - `in_*` values not yet accepted are never forwarded.
  - `hold` has no effect on lookup.
- **Reset:** asserting `rst_n` low at any time empties the queue; pending writes are discarded.

## Timing
- **Reset values:**
  - `RegWrite=0`, `rd=0`, `WriteData=0`, `count=0`.
  - `in_ready=1`, `fwd*_hit=0`, `fwd*_data=0`.
  - All outputs reach these values asynchronously on reset assertion, including mid-drain.
- **Latency:** an entry accepted at edge N is presented on `RegWrite` in cycle N→N+1 (if it is at head and `hold=0`). It is committed in `RegFile` at edge N+1.
- **Output paths:** `RegWrite`, `rd`, `WriteData`, `in_ready`, and forwarding outputs are combinational from state plus `hold`/`rs*`. There is no combinational path from `in_*` to any output.
- **Count:** `count` updates at posedge as +1 (push only), −1 (pop only), or unchanged (both or neither).
- **Throughput:** one push and one pop per cycle sustained.

## Configuration
- Macro `WB_QUEUE_FWD_EN`.
- **Defined:** forwarding lookup is built as described above.
- **Undefined:**
  - Lookup logic is omitted.
  - `fwd1_hit`/`fwd2_hit` are tied to 0 and `fwd1_data`/`fwd2_data` to 0.
  - Ports remain present.
  - Queue behaviour is otherwise identical.

## Test plan
- **Basic write:** after reset, push rd=5, data=123 at edge 1.
  - Expect `RegWrite=1`, `rd=5`, `WriteData=123` in the next cycle.
  - `RegFile` x5 reads 123 after edge 2; `count` returns to 0.
- **Fill and hold:** `hold=1`, push rd=1..4 with data 10,20,30,40.
  - Expect `count=4` and `in_ready=0`.
  - Release `hold`: drain in order 10,20,30,40 on four consecutive cycles.
- **Full push/pop:** with the queue full and `hold=0`, push rd=6, data=99 in the same cycle as the pop of the head.
  - Expect `in_ready=1`, `count` stays 4, and 99 drains last.
- **Forwarding (macro defined):** `hold=1`, push rd=7/data=1 then rd=7/data=2.
  - `rs1=7` gives `fwd1_hit=1`, `fwd1_data=2`.
  - `rs2=0` gives `fwd2_hit=0`.
  - After draining, both hits are 0.
- **x0 write:** push rd=0, data=55.
  - Handshake completes, `count` stays 0, `RegWrite` never asserts.
- **Reset mid-drain:** with 3 entries queued, pulse `rst_n` low between edges.
  - `RegWrite` drops to 0 immediately and `count=0`.
  - No further writes reach `RegFile`.
